maindec_mc: RTL and testbench
=============================

MAINDEC_MC -- requirements
Module: maindec_mc

Interface
REQ-001 The block SHALL have one parameter: ALUOP_W, default 4, width of the aluop output.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 op  input  6  instruction opcode, valid from DECODE onward.
REQ-006 funct  input  6  R-type function field.
REQ-007 mem_ready  input  1  memory completes the current request this cycle.
REQ-008 irwrite  output  1  load instruction register.
REQ-009 pcwrite  output  1  unconditional PC write.
REQ-010 brtype  output  2  conditional PC write: 00 none, 01 beq, 10 bne, 11 blez.
REQ-011 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs.
REQ-012 alusrca  output  1  ALU A source: 0 PC, 1 rs.
REQ-013 alusrcb  output  2  ALU B source: 00 rt, 01 constant 4, 10 imm, 11 imm<<2.
REQ-014 iord  output  1  memory address source: 0 PC, 1 ALUOut.
REQ-015 mem_req  output  1  memory access request.
REQ-016 memwrite  output  1  the request is a write.
REQ-017 memtoreg  output  1  register write data comes from memory.
REQ-018 regdst  output  1  destination register is rd (otherwise rt).
REQ-019 regwrite  output  1  register file write.
REQ-020 link  output  1  write PC to $31 (jal).
REQ-021 ld_size  output  2  load size: 00 word, 01 half, 10 byte, 11 byte-unsigned.
REQ-022 aluop  output  ALUOP_W  ALU operation code from the shared package.
REQ-023 illegal  output  1  illegal-opcode trap is active.

Function
REQ-024 The block SHALL be a multicycle controller. Outputs are Moore outputs of the state, except irwrite and pcwrite in FETCH. Every output not listed for a state SHALL be 0.
REQ-025 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=ALU_ADD. irwrite and pcwrite SHALL be 1 only in the cycle where mem_ready=1. The FSM holds in FETCH while mem_ready=0 and moves to DECODE on mem_ready=1.
REQ-026 DECODE: alusrcb=11, aluop=ALU_ADD. Next state by op: lw/lh/lb/lbu/sw -> MEMADR; R-type -> REXEC; addi/ori/andi/xori/slti/lui -> IEXEC; beq/bne/blez -> BRANCH; j -> JUMP; jal -> JAL.
REQ-027 op=000000 with funct=001000 SHALL decode as jr and go to JR, taking priority over R-type.
REQ-028 MEMADR: alusrca=1, alusrcb=10, aluop=ALU_ADD. Loads go to MEMRD; sw goes to MEMWR.
REQ-029 MEMRD: mem_req=1, iord=1, ld_size valid. The FSM holds while mem_ready=0, then goes to MEMWB.
REQ-030 MEMWB: regwrite=1, memtoreg=1, regdst=0, ld_size held. Then FETCH.
REQ-031 MEMWR: mem_req=1, memwrite=1, iord=1. The FSM holds while mem_ready=0, then goes to FETCH.
REQ-032 While a wait-state holds, mem_req, memwrite, iord and ld_size SHALL stay constant.
REQ-033 REXEC: alusrca=1, alusrcb=00, aluop=ALU_FUNCT -> ALUWB. ALUWB: regwrite=1, regdst=1 -> FETCH.
REQ-034 IEXEC: alusrca=1, alusrcb=10, aluop = ALU_ADD/OR/AND/XOR/SLT/LUI according to op -> IWB. IWB: regwrite=1, regdst=0 -> FETCH.
REQ-035 BRANCH: alusrca=1, alusrcb=00, pcsrc=01. aluop=ALU_SUB for beq/bne and ALU_SLT for blez. brtype per op. Then FETCH.
REQ-036 JUMP: pcwrite=1, pcsrc=10. JAL: the same plus regwrite=1, link=1. JR: pcwrite=1, pcsrc=11. All three go to FETCH.
REQ-037 Instruction latencies (zero memory wait) SHALL be: lw 5, sw 4, R-type 4, I-type 4, branch 3, j/jal/jr 3 cycles. Each memory wait cycle adds 1.
REQ-038 op and funct SHALL be sampled only in DECODE. The load type SHALL be registered there for use in MEMRD and MEMWB.

Reset
REQ-039 Asserting reset SHALL immediately force FETCH and clear the registered load type. This applies at any time, including during a memory wait.
REQ-040 During reset all outputs SHALL be 0, including mem_req. The first FETCH request SHALL appear in the cycle after reset deasserts.

Configuration
REQ-041 With MAINDEC_MC_ILLEGAL_TRAP_EN defined, an unknown op in DECODE SHALL enter TRAP. TRAP holds illegal=1 with all other outputs 0 and is left only by reset.
REQ-042 Without MAINDEC_MC_ILLEGAL_TRAP_EN, an unknown op SHALL return to FETCH as a NOP, the illegal output SHALL be tied to 0, and no TRAP state SHALL exist.

Structure
REQ-043 A shared package mips_mc_pkg SHALL hold: the state enum, the opcode/funct constants, the aluop constants (ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_OR, ALU_AND, ALU_XOR, ALU_SLT, ALU_LUI), and the ld_size and brtype encodings.
REQ-044 The block SHALL contain one sub-module, maindec_mc_next: combinational next-state and op-class decode. The state register and output decode stay in the top module.

Verification
REQ-045 lw (op=100011), mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB in 5 cycles; regwrite=1, memtoreg=1 only in MEMWB.
REQ-046 sw with mem_ready low for 2 cycles in MEMWR -> MEMWR held for 3 cycles with mem_req=1 and memwrite=1 steady; then FETCH.
REQ-047 op=0, funct=001000 -> JR with pcwrite=1, pcsrc=11; regwrite stays 0 for the whole instruction.
REQ-048 blez (op=000110) -> BRANCH with brtype=11, aluop=ALU_SLT, pcsrc=01; 3 cycles in total.
REQ-049 reset asserted in the 2nd MEMRD wait cycle -> mem_req=0 in the same cycle; FETCH the cycle after reset deasserts.
REQ-050 op=111111: with the macro -> illegal=1 held through 10 cycles; without it -> FETCH follows DECODE and illegal stays 0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM states, opcode
// and funct constants, ALU operation codes, load-size and branch-type codes.
// Optional feature macro: MAINDEC_MC_ILLEGAL_TRAP_EN adds the TRAP state.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REXEC,
        S_ALUWB,
        S_IEXEC,
        S_IWB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_JR
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    // Where an unknown opcode goes after DECODE.
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
    localparam state_t S_UNKNOWN_OP = S_TRAP;
`else
    localparam state_t S_UNKNOWN_OP = S_FETCH;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_AND   = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_LUI   = 4'd7;

    localparam logic [1:0] LD_WORD  = 2'b00;
    localparam logic [1:0] LD_HALF  = 2'b01;
    localparam logic [1:0] LD_BYTE  = 2'b10;
    localparam logic [1:0] LD_BYTEU = 2'b11;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_BLEZ = 2'b11;

    // Per-instruction facts captured in DECODE so later states never look at op.
    typedef struct packed {
        logic       is_store;
        logic [1:0] ld_size;
        logic [3:0] aluop;
        logic [1:0] brtype;
    } opcls_t;

endpackage

// File: rtl/maindec_mc_next.sv
// Next-state logic and opcode-class decode for the multicycle controller.
module maindec_mc_next
    import mips_mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    input  logic       is_store_q_i,
    output state_t     state_d_o,
    output opcls_t     cls_d_o
);

    state_t dec_state;

    // Classify the opcode: target state after DECODE plus facts to register.
    always_comb begin
        cls_d_o   = '0;
        dec_state = S_UNKNOWN_OP;
        case (op_i)
            // jr shares op=0 with R-type and wins over it
            OP_RTYPE: dec_state = (funct_i == FN_JR) ? S_JR : S_REXEC;
            OP_LW:   begin dec_state = S_MEMADR; cls_d_o.ld_size = LD_WORD;  end
            OP_LH:   begin dec_state = S_MEMADR; cls_d_o.ld_size = LD_HALF;  end
            OP_LB:   begin dec_state = S_MEMADR; cls_d_o.ld_size = LD_BYTE;  end
            OP_LBU:  begin dec_state = S_MEMADR; cls_d_o.ld_size = LD_BYTEU; end
            OP_SW:   begin dec_state = S_MEMADR; cls_d_o.is_store = 1'b1;    end
            OP_ADDI: begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_ADD;    end
            OP_ORI:  begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_OR;     end
            OP_ANDI: begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_AND;    end
            OP_XORI: begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_XOR;    end
            OP_SLTI: begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_SLT;    end
            OP_LUI:  begin dec_state = S_IEXEC;  cls_d_o.aluop = ALU_LUI;    end
            OP_BEQ:  begin dec_state = S_BRANCH; cls_d_o.aluop = ALU_SUB; cls_d_o.brtype = BR_BEQ;  end
            OP_BNE:  begin dec_state = S_BRANCH; cls_d_o.aluop = ALU_SUB; cls_d_o.brtype = BR_BNE;  end
            OP_BLEZ: begin dec_state = S_BRANCH; cls_d_o.aluop = ALU_SLT; cls_d_o.brtype = BR_BLEZ; end
            OP_J:    dec_state = S_JUMP;
            OP_JAL:  dec_state = S_JAL;
            default: ;
        endcase
    end

    // State transitions; memory states hold until mem_ready.
    always_comb begin
        state_d_o = S_FETCH;
        case (state_i)
            S_FETCH:  state_d_o = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d_o = dec_state;
            S_MEMADR: state_d_o = is_store_q_i ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d_o = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d_o = mem_ready_i ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d_o = S_ALUWB;
            S_IEXEC:  state_d_o = S_IWB;
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d_o = S_TRAP;
`endif
            default:  state_d_o = S_FETCH;
        endcase
    end

endmodule

// File: rtl/maindec_mc.sv
// Multicycle MIPS main decoder: state register, registered op class, and
// Moore output decode (irwrite/pcwrite in FETCH follow mem_ready).
// Optional feature macro: MAINDEC_MC_ILLEGAL_TRAP_EN (unknown op -> TRAP).
module maindec_mc
    import mips_mc_pkg::*;
#(
    parameter int ALUOP_W = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               irwrite,
    output logic               pcwrite,
    output logic [1:0]         brtype,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               iord,
    output logic               mem_req,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               link,
    output logic [1:0]         ld_size,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal
);

    state_t     state_q, state_d;
    opcls_t     cls_q, cls_d;
    logic [3:0] aluop_w;

    maindec_mc_next u_next (
        .state_i      (state_q),
        .op_i         (op),
        .funct_i      (funct),
        .mem_ready_i  (mem_ready),
        .is_store_q_i (cls_q.is_store),
        .state_d_o    (state_d),
        .cls_d_o      (cls_d)
    );

    // State register; reset forces FETCH even mid memory wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Op class is captured only in DECODE so op may change afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    cls_q <= '0;
        else if (state_q == S_DECODE) cls_q <= cls_d;
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        brtype   = BR_NONE;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        iord     = 1'b0;
        mem_req  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        link     = 1'b0;
        ld_size  = LD_WORD;
        aluop_w  = ALU_ADD;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
                S_MEMRD:  begin mem_req = 1'b1; iord = 1'b1; ld_size = cls_q.ld_size; end
                S_MEMWB:  begin regwrite = 1'b1; memtoreg = 1'b1; ld_size = cls_q.ld_size; end
                S_MEMWR:  begin mem_req = 1'b1; memwrite = 1'b1; iord = 1'b1; end
                S_REXEC:  begin alusrca = 1'b1; aluop_w = ALU_FUNCT; end
                S_ALUWB:  begin regwrite = 1'b1; regdst = 1'b1; end
                S_IEXEC:  begin alusrca = 1'b1; alusrcb = 2'b10; aluop_w = cls_q.aluop; end
                S_IWB:    regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca = 1'b1;
                    pcsrc   = 2'b01;
                    aluop_w = cls_q.aluop;
                    brtype  = cls_q.brtype;
                end
                S_JUMP:   begin pcwrite = 1'b1; pcsrc = 2'b10; end
                S_JAL:    begin pcwrite = 1'b1; pcsrc = 2'b10; regwrite = 1'b1; link = 1'b1; end
                S_JR:     begin pcwrite = 1'b1; pcsrc = 2'b11; end
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
                S_TRAP:   illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign aluop = ALUOP_W'(aluop_w);

endmodule

// File: tb/tb_maindec_mc.sv
// Self-checking bench for maindec_mc: directed instructions plus a random
// instruction stream, each expanded by a reference model into the expected
// per-cycle control bundle.
module tb_maindec_mc;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       mem_ready;
    logic       irwrite, pcwrite, alusrca, iord, mem_req, memwrite;
    logic       memtoreg, regdst, regwrite, link, illegal;
    logic [1:0] brtype, pcsrc, alusrcb, ld_size;
    logic [3:0] aluop;

    typedef struct packed {
        logic       irwrite, pcwrite;
        logic [1:0] brtype, pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord, mem_req, memwrite, memtoreg, regdst, regwrite, link;
        logic [1:0] ld_size;
        logic [3:0] aluop;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        logic  mr;
        logic  drv;
        ctrl_t exp;
    } step_t;

    ctrl_t      obs;
    step_t      q[$];
    logic [5:0] cur_op, cur_funct;
    string      cur_name;
    int         vectors = 0;
    int         miscompares = 0;

    logic [5:0] legal_ops [17] = '{6'b100011, 6'b100001, 6'b100000, 6'b100100, 6'b101011,
                                   6'b000000, 6'b001000, 6'b001101, 6'b001100, 6'b001110,
                                   6'b001010, 6'b001111, 6'b000100, 6'b000101, 6'b000110,
                                   6'b000010, 6'b000011};

    maindec_mc #(.ALUOP_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .irwrite(irwrite), .pcwrite(pcwrite), .brtype(brtype), .pcsrc(pcsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .mem_req(mem_req),
        .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .link(link), .ld_size(ld_size), .aluop(aluop),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {irwrite, pcwrite, brtype, pcsrc, alusrca, alusrcb, iord, mem_req,
                  memwrite, memtoreg, regdst, regwrite, link, ld_size, aluop, illegal};

    task automatic check(input string tag, input ctrl_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input ctrl_t c, input logic mr, input logic drv);
        step_t s;
        s.mr = mr; s.drv = drv; s.exp = c;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle-by-cycle behaviour.
    // fw = fetch wait cycles, mw = data-memory wait cycles.
    task automatic build(input string name, input logic [5:0] bop, input logic [5:0] bf,
                         input int fw, input int mw);
        ctrl_t c;
        logic [1:0] sz;
        q.delete();
        cur_name = name; cur_op = bop; cur_funct = bf;
        c = '0; c.mem_req = 1; c.alusrcb = 2'b01; c.aluop = ALU_ADD;
        for (int i = 0; i < fw; i++) push(c, 1'b0, 1'b0);
        c.irwrite = 1; c.pcwrite = 1;
        push(c, 1'b1, 1'b0);
        c = '0; c.alusrcb = 2'b11; c.aluop = ALU_ADD;
        push(c, 1'($urandom_range(0, 1)), 1'b1);
        case (bop)
            6'b100011, 6'b100001, 6'b100000, 6'b100100: begin
                sz = (bop == 6'b100001) ? 2'b01 : (bop == 6'b100000) ? 2'b10 :
                     (bop == 6'b100100) ? 2'b11 : 2'b00;
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = ALU_ADD;
                push(c, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.mem_req = 1; c.iord = 1; c.ld_size = sz;
                for (int i = 0; i < mw; i++) push(c, 1'b0, 1'b0);
                push(c, 1'b1, 1'b0);
                c = '0; c.regwrite = 1; c.memtoreg = 1; c.ld_size = sz;
                push(c, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b101011: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10; c.aluop = ALU_ADD;
                push(c, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.mem_req = 1; c.memwrite = 1; c.iord = 1;
                for (int i = 0; i < mw; i++) push(c, 1'b0, 1'b0);
                push(c, 1'b1, 1'b0);
            end
            6'b000000: begin
                if (bf == 6'b001000) begin
                    c = '0; c.pcwrite = 1; c.pcsrc = 2'b11;
                    push(c, 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    c = '0; c.alusrca = 1; c.alusrcb = 2'b00; c.aluop = ALU_FUNCT;
                    push(c, 1'($urandom_range(0, 1)), 1'b0);
                    c = '0; c.regwrite = 1; c.regdst = 1;
                    push(c, 1'($urandom_range(0, 1)), 1'b0);
                end
            end
            6'b001000, 6'b001101, 6'b001100, 6'b001110, 6'b001010, 6'b001111: begin
                c = '0; c.alusrca = 1; c.alusrcb = 2'b10;
                case (bop)
                    6'b001000: c.aluop = ALU_ADD;
                    6'b001101: c.aluop = ALU_OR;
                    6'b001100: c.aluop = ALU_AND;
                    6'b001110: c.aluop = ALU_XOR;
                    6'b001010: c.aluop = ALU_SLT;
                    default:   c.aluop = ALU_LUI;
                endcase
                push(c, 1'($urandom_range(0, 1)), 1'b0);
                c = '0; c.regwrite = 1;
                push(c, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b000100, 6'b000101, 6'b000110: begin
                c = '0; c.alusrca = 1; c.pcsrc = 2'b01;
                c.aluop  = (bop == 6'b000110) ? ALU_SLT : ALU_SUB;
                c.brtype = (bop == 6'b000100) ? 2'b01 : (bop == 6'b000101) ? 2'b10 : 2'b11;
                push(c, 1'($urandom_range(0, 1)), 1'b0);
            end
            6'b000010, 6'b000011: begin
                c = '0; c.pcwrite = 1; c.pcsrc = 2'b10;
                if (bop == 6'b000011) begin c.regwrite = 1; c.link = 1; end
                push(c, 1'($urandom_range(0, 1)), 1'b0);
            end
            default: begin
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
                c = '0; c.illegal = 1;
                for (int i = 0; i < 10; i++) push(c, 1'($urandom_range(0, 1)), 1'b0);
`endif
            end
        endcase
    endtask

    // Play the expanded steps; op/funct are only meaningful in DECODE, so
    // they are scrambled in every other cycle. abort_at asserts reset there.
    task automatic run(input int abort_at);
        ctrl_t e;
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk); #1;
            mem_ready = q[i].mr;
            if (q[i].drv) begin op = cur_op; funct = cur_funct; end
            else begin op = 6'($urandom); funct = 6'($urandom); end
            if (i == abort_at) reset = 1'b1;
            #3;
            e = (i == abort_at) ? ctrl_t'('0) : q[i].exp;
            check($sformatf("%s[%0d]", cur_name, i), e);
            if (i == abort_at) break;
        end
    endtask

    // Hold reset for a cycle, release it and check the first FETCH request.
    task automatic reset_cycle();
        ctrl_t c;
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b1;
        #3 check("in_reset", '0);
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        c = '0; c.mem_req = 1; c.alusrcb = 2'b01; c.aluop = ALU_ADD;
        #3 check("post_reset_fetch", c);
    endtask

    initial begin
        logic [5:0] rop, rf;
        reset = 1'b1; mem_ready = 1'b1; op = '0; funct = '0;
        #2 check("reset_t0", '0);
        reset_cycle();

        build("lw", 6'b100011, 6'h00, 0, 0);  run(-1);
        build("sw_wait2", 6'b101011, 6'h00, 0, 2);  run(-1);
        build("jr", 6'b000000, 6'b001000, 0, 0);  run(-1);
        build("blez", 6'b000110, 6'h00, 0, 0);  run(-1);
        build("lbu_fw", 6'b100100, 6'h00, 2, 1);  run(-1);
        build("add", 6'b000000, 6'b100000, 0, 0);  run(-1);
        build("jal", 6'b000011, 6'h00, 1, 0);  run(-1);

        // reset in the 2nd MEMRD wait cycle (step 4 of a zero-fetch-wait lw)
        build("lw_rst", 6'b100011, 6'h00, 0, 3);  run(4);
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        #3 check("rst_release_fetch", '{mem_req: 1'b1, alusrcb: 2'b01, aluop: ALU_ADD, default: '0});
        build("lh_after_rst", 6'b100001, 6'h00, 0, 0);  run(-1);

        for (int n = 0; n < 150; n++) begin
            rop = legal_ops[$urandom_range(0, 16)];
            rf  = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
`ifndef MAINDEC_MC_ILLEGAL_TRAP_EN
            if ($urandom_range(0, 9) == 0) rop = ($urandom_range(0, 1) == 1) ? 6'b111111 : 6'b010001;
`endif
            build($sformatf("rnd%0d_op%02h", n, rop), rop, rf,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            run(-1);
        end

        // unknown opcode: trap holds until reset, or NOP back to FETCH
        build("op3f", 6'b111111, 6'h00, 0, 0);  run(-1);
`ifdef MAINDEC_MC_ILLEGAL_TRAP_EN
        reset_cycle();
`endif
        build("lw_final", 6'b100011, 6'h00, 0, 0);  run(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
